// File: rtl/elastic_arb_pkg.sv
// elastic_arb_pkg: shared FSM state type and one-hot helper for the round-robin arbiter
package elastic_arb_pkg;

    typedef enum logic {IDLE, BUSY} arb_state_t;

    // One-hot vector with bit idx set; zero when idx is outside [0, n).
    function automatic logic [63:0] onehot(input int idx, input int n);
        return (idx >= 0 && idx < n) ? (64'd1 << idx) : 64'd0;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// rr_priority_pick: combinational round-robin pick, first set bit of req at or after ptr (mod NREQ)
//  req   in   NREQ  request vector
//  ptr   in   IW    search start index
//  found out  1     any request set
//  idx   out  IW    winning index
module rr_priority_pick #(
    parameter int NREQ = 4,
    parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic            found,
    output logic [IW-1:0]   idx
);

    logic [NREQ-1:0] w_rot;
    logic [IW-1:0]   w_off;
    logic [IW:0]     w_sum;

    // Shifting the doubled vector right by ptr rotates req so ptr lands at bit 0.
    assign w_rot = NREQ'({req, req} >> ptr);

    always_comb begin
        found = 1'b0;
        w_off = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                found = 1'b1;
                w_off = IW'(i);
            end
        end
        w_sum = {1'b0, ptr} + {1'b0, w_off};
        idx   = (w_sum >= (IW+1)'(NREQ)) ? IW'(w_sum - (IW+1)'(NREQ)) : IW'(w_sum);
    end

endmodule

// File: rtl/elastic_rr_arbiter.sv
// elastic_rr_arbiter: burst-locked round-robin arbiter feeding one registered valid/ready stage
//  clk, rst                       clock, async active-high reset
//  req_data_i/req_valid_i         per-requester beats (requester k at [k*DW +: DW])
//  req_ready_o                    per-requester ready, at most one bit high
//  out_data_o/out_valid_o/out_src_o  registered output beat and its source index
//  out_ready_i                    downstream ready
//  grant_o                        one-hot current grant, zero while idle
module elastic_rr_arbiter
    import elastic_arb_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int DW    = 16,
    parameter int BURST = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ*DW-1:0]   req_data_i,
    input  logic [NREQ-1:0]      req_valid_i,
    output logic [NREQ-1:0]      req_ready_o,
    output logic [DW-1:0]        out_data_o,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [((NREQ > 1) ? $clog2(NREQ) : 1)-1:0] out_src_o,
    output logic [NREQ-1:0]      grant_o
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(BURST + 1);

    arb_state_t      r_state, w_state_nxt;
    logic [IW-1:0]   r_rr_ptr, w_rr_ptr_nxt;
    logic [IW-1:0]   r_g, w_g_nxt;
    logic [CW-1:0]   r_beat_cnt, w_beat_cnt_nxt;
    logic [NREQ-1:0] r_grant, w_grant_nxt;
    logic            r_out_valid, w_out_valid_nxt;
    logic [DW-1:0]   r_out_data, w_out_data_nxt;
    logic [IW-1:0]   r_out_src, w_out_src_nxt;

    logic            w_pick_found;
    logic [IW-1:0]   w_pick_idx;
    logic            w_busy, w_stage_free, w_g_valid, w_accept, w_release;
    logic [DW-1:0]   w_g_data;

    rr_priority_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
        .req   (req_valid_i),
        .ptr   (r_rr_ptr),
        .found (w_pick_found),
        .idx   (w_pick_idx)
    );

    assign w_busy       = r_state == BUSY;
    assign w_stage_free = !r_out_valid || out_ready_i;
    assign w_g_valid    = req_valid_i[r_g];
    assign w_g_data     = req_data_i[r_g*DW +: DW];
    assign w_accept     = w_busy && w_stage_free && w_g_valid;
    // Release only when the stage can move: either the burst's last beat is taken now
    // or the granted requester has nothing more to send.
    assign w_release    = w_busy && w_stage_free && (!w_g_valid || r_beat_cnt == CW'(BURST - 1));
    assign req_ready_o  = (w_busy && w_stage_free) ? r_grant : '0;

    always_comb begin
        w_state_nxt     = r_state;
        w_rr_ptr_nxt    = r_rr_ptr;
        w_g_nxt         = r_g;
        w_beat_cnt_nxt  = r_beat_cnt;
        w_grant_nxt     = r_grant;
        w_out_valid_nxt = r_out_valid && !out_ready_i;
        w_out_data_nxt  = r_out_data;
        w_out_src_nxt   = r_out_src;
        if (!w_busy && w_pick_found) begin
            w_state_nxt    = BUSY;
            w_g_nxt        = w_pick_idx;
            w_grant_nxt    = NREQ'(onehot(int'(w_pick_idx), NREQ));
            w_beat_cnt_nxt = '0;
        end
        if (w_accept) begin
            w_out_valid_nxt = 1'b1;
            w_out_data_nxt  = w_g_data;
            w_out_src_nxt   = r_g;
            w_beat_cnt_nxt  = r_beat_cnt + CW'(1);
        end
        if (w_release) begin
            w_state_nxt  = IDLE;
            w_grant_nxt  = '0;
            w_rr_ptr_nxt = (r_g == IW'(NREQ - 1)) ? '0 : r_g + IW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_rr_ptr    <= '0;
            r_g         <= '0;
            r_beat_cnt  <= '0;
            r_grant     <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_src   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_rr_ptr    <= w_rr_ptr_nxt;
            r_g         <= w_g_nxt;
            r_beat_cnt  <= w_beat_cnt_nxt;
            r_grant     <= w_grant_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_out_data  <= w_out_data_nxt;
            r_out_src   <= w_out_src_nxt;
        end
    end

    assign out_valid_o = r_out_valid;
    assign out_data_o  = r_out_data;
    assign out_src_o   = r_out_src;
    assign grant_o     = r_grant;

endmodule

// File: tb/tb_elastic_rr_arbiter.sv
// tb_elastic_rr_arbiter: directed scoreboard bench for elastic_rr_arbiter
module tb_elastic_rr_arbiter;

    localparam int NREQ  = 4;
    localparam int DW    = 16;
    localparam int BURST = 4;

    typedef struct packed {
        logic [1:0]    src;
        logic [DW-1:0] data;
    } beat_t;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    req_valid, req_ready, grant, hs;
    logic [DW-1:0]      out_data;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic [1:0]         out_src;

    int    cnt[NREQ];
    int    seq[NREQ];
    beat_t q[$];
    beat_t e_m;
    int    checks = 0;
    int    errors = 0;

    always #5 clk = ~clk;

    elastic_rr_arbiter #(.NREQ(NREQ), .DW(DW), .BURST(BURST)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_data_i  (req_data),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .out_data_o  (out_data),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_src_o   (out_src),
        .grant_o     (grant)
    );

    // Requester k offers cnt[k] more beats; beat payload is {k, sequence number}.
    always_comb begin
        for (int k = 0; k < NREQ; k++) begin
            req_data[k*DW +: DW] = {4'(k), 12'(seq[k])};
            req_valid[k]         = cnt[k] != 0;
        end
    end

    initial begin
        for (int k = 0; k < NREQ; k++) begin
            cnt[k] = 0;
            seq[k] = 0;
        end
        forever begin
            @(posedge clk);
            hs = req_ready & req_valid;
            #1;
            for (int k = 0; k < NREQ; k++) begin
                if (hs[k]) begin
                    seq[k] = seq[k] + 1;
                    cnt[k] = cnt[k] - 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL beat: got src %0d data %h, expected no beat", out_src, out_data);
            end else begin
                e_m = q.pop_front();
                if ({out_src, out_data} !== e_m) begin
                    errors++;
                    $display("FAIL beat: got src %0d data %h, expected src %0d data %h",
                             out_src, out_data, e_m.src, e_m.data);
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
        end
    endtask

    task automatic push(input int s, input int first, input int n);
        for (int i = 0; i < n; i++) q.push_back({2'(s), 4'(s), 12'(first + i)});
    endtask

    task automatic clear_reqs();
        for (int k = 0; k < NREQ; k++) begin
            cnt[k] = 0;
            seq[k] = 0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc(1);
        clear_reqs();
        out_ready = 1'b1;
        cyc(1);
        rst = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (q.size() != 0 && n < 200) begin
            cyc(1);
            n++;
        end
        chk({name, " drained"}, q.size(), 0);
        cyc(3);
    endtask

    initial begin
        // 1: reset while a beat sits stalled in the stage
        do_reset();
        out_ready = 1'b0;
        cnt[1] = 10;
        cyc(3);
        chk("t1 pre valid", out_valid, 1);
        rst = 1'b1;
        #1;
        chk("t1 rst valid", out_valid, 0);
        chk("t1 rst data", out_data, 0);
        chk("t1 rst src", out_src, 0);
        chk("t1 rst grant", grant, 0);
        chk("t1 rst ready", req_ready, 0);
        clear_reqs();
        cyc(1);
        out_ready = 1'b1;
        cnt[1] = 2;
        cnt[3] = 1;
        push(1, 0, 2);
        push(3, 0, 1);
        rst = 1'b0;
        cyc(1);
        chk("t1 first grant", grant, 4'b0010);
        drain("t1");

        // 2: all valid, bursts of 4 in order 0,1,2,3,0
        do_reset();
        cnt[0] = 8; cnt[1] = 4; cnt[2] = 4; cnt[3] = 4;
        push(0, 0, 4); push(1, 0, 4); push(2, 0, 4); push(3, 0, 4); push(0, 4, 4);
        cyc(1);
        chk("t2 grant0", grant, 4'b0001);
        cyc(4);
        chk("t2 bubble grant", grant, 0);
        chk("t2 bubble ready", req_ready, 0);
        cyc(1);
        chk("t2 grant1", grant, 4'b0010);
        drain("t2");

        // 3: only req2, 10 beats split 4,4,2
        do_reset();
        cnt[2] = 10;
        push(2, 0, 10);
        cyc(1);  chk("t3 burst1", grant, 4'b0100);
        cyc(4);  chk("t3 gap1", grant, 0);
        cyc(1);  chk("t3 burst2", grant, 4'b0100);
        cyc(4);  chk("t3 gap2", grant, 0);
        cyc(1);  chk("t3 burst3", grant, 4'b0100);
        cyc(2);  chk("t3 burst3 busy", grant, 4'b0100);
        cyc(1);  chk("t3 done", grant, 0);
        drain("t3");

        // 4: backpressure mid-burst
        do_reset();
        cnt[0] = 6;
        push(0, 0, 6);
        cyc(3);
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc(1);
            chk("t4 stall data", out_data, 16'h0001);
            chk("t4 stall valid", out_valid, 1);
            chk("t4 stall ready", req_ready, 0);
            chk("t4 stall grant", grant, 4'b0001);
        end
        chk("t4 one buffered", seq[0], 2);
        out_ready = 1'b1;
        drain("t4");

        // 5: req1 quits after 2 beats, next pick starts at 2
        do_reset();
        cnt[0] = 1; cnt[1] = 2; cnt[3] = 1;
        push(0, 0, 1); push(1, 0, 2); push(3, 0, 1);
        cyc(8);
        chk("t5 grant3", grant, 4'b1000);
        drain("t5");

        // 6: ptr=3 with only req0/req1 valid wraps to 0, then 1
        do_reset();
        cnt[2] = 1;
        push(2, 0, 1);
        drain("t6 setup");
        cnt[0] = 1; cnt[1] = 1;
        push(0, 0, 1); push(1, 0, 1);
        cyc(1);
        chk("t6 wrap grant", grant, 4'b0001);
        drain("t6");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
